// File: rtl/uart_rx.sv
// 8-bit UART receiver with oversampled mid-bit sampling, start/stop validation and one-cycle result pulses.
// Optional parity stage enabled by defining UART_RX_PARITY_EN (8E1/8O1 selected by PARITY_ODD).
module uart_rx #(
    parameter int unsigned sys_freq   = 100_000_000,
    parameter int unsigned BAUD_rate  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam int unsigned DIV   = sys_freq / (BAUD_rate * OVERSAMPLE);
    localparam int unsigned CNT_W = ($clog2(DIV) > 16) ? $clog2(DIV) : 16;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV - 1);
    localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  FULL_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic             PAR_ODD   = 1'(PARITY_ODD);

`ifdef UART_RX_PARITY_EN
    localparam logic PARITY_HW = 1'b1;
`else
    localparam logic PARITY_HW = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta, rx_s;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_bit_q, par_bit_d;
    logic [7:0]       rx_data_d;
    logic             rx_valid_d, frame_err_d, parity_err_d, busy_d;
    logic             tick_c, sample_c;

    // Sample point: half a bit into the start bit, then every full bit.
    assign tick_c   = (tick_cnt_q == TICK_LAST);
    assign sample_c = tick_c &&
                      (os_cnt_q == ((state_q == S_START) ? HALF_LAST : FULL_LAST));

    always_ff @(posedge clk) begin
        if (reset_p) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            os_cnt_q   <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            par_bit_q  <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            os_cnt_q   <= os_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            par_bit_q  <= par_bit_d;
            rx_data    <= rx_data_d;
            rx_valid   <= rx_valid_d;
            frame_err  <= frame_err_d;
            parity_err <= parity_err_d;
            busy       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_c ? '0 : tick_cnt_q + 1'b1;
        os_cnt_d     = os_cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        par_bit_d    = par_bit_q;
        rx_data_d    = rx_data;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;

        if (tick_c) begin
            os_cnt_d = sample_c ? '0 : os_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // Clearing the divider phase-aligns ticks to the start edge.
                if (!rx_s) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    os_cnt_d   = '0;
                end
            end
            S_START: begin
                if (sample_c) begin
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (sample_c) begin
                    shreg_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (sample_c) begin
                    par_bit_d = rx_s;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (sample_c) begin
                    if (rx_s) begin
                        rx_data_d    = shreg_q;
                        rx_valid_d   = 1'b1;
                        parity_err_d = PARITY_HW & (par_bit_q ^ (^shreg_q) ^ PAR_ODD);
                        state_d      = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: reset, good frames, false start, framing error/break,
// back-to-back frames, mid-frame reset and (with UART_RX_PARITY_EN) a parity error.
module tb_uart_rx;
    localparam int unsigned SYS_FREQ = 6_400_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned OS       = 16;
    localparam int unsigned DIV      = SYS_FREQ / (BAUD * OS);
    localparam int unsigned BIT      = DIV * OS;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int n_valid      = 0;
    int n_ferr       = 0;
    int n_perr       = 0;
    int n_perr_valid = 0;
    int n_overlap    = 0;
    logic [7:0] data_log [16];

    uart_rx #(
        .sys_freq  (SYS_FREQ),
        .BAUD_rate (BAUD),
        .OVERSAMPLE(OS),
        .PARITY_ODD(0)
    ) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            data_log[4'(n_valid)] <= rx_data;
            n_valid               <= n_valid + 1;
            if (parity_err) n_perr_valid <= n_perr_valid + 1;
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (parity_err) n_perr <= n_perr + 1;
        if (rx_valid && frame_err) n_overlap <= n_overlap + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int unsigned n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
`ifdef UART_RX_PARITY_EN
        hold(^d, BIT);
`endif
        hold(stop, BIT);
    endtask

    int v0, f0;

    initial begin
        reset_p = 1'b1;
        rx      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", int'(rx_data), 0);
        check("rst_valid", int'(rx_valid), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_perr", int'(parity_err), 0);
        check("rst_busy", int'(busy), 0);
        reset_p = 1'b0;
        hold(1'b1, 20);

        // Single good frame
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'hA5, 1'b1);
        hold(1'b1, 4);
        check("a5_count", n_valid - v0, 1);
        check("a5_data", int'(rx_data), 8'hA5);
        check("a5_ferr", n_ferr - f0, 0);
        check("a5_busy", int'(busy), 0);

        // Short low glitch is a false start
        v0 = n_valid; f0 = n_ferr;
        hold(1'b0, 8);
        check("glitch_busy_hi", int'(busy), 1);
        hold(1'b0, 3 * DIV - 8);
        hold(1'b1, 2 * BIT);
        check("glitch_valid", n_valid - v0, 0);
        check("glitch_ferr", n_ferr - f0, 0);
        check("glitch_busy_lo", int'(busy), 0);

        // Bad stop bit followed by a held-low line, then recovery
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        hold(1'b0, 5 * BIT);
        check("brk_busy_hi", int'(busy), 1);
        hold(1'b1, 2 * BIT);
        check("brk_ferr", n_ferr - f0, 1);
        check("brk_valid", n_valid - v0, 0);
        check("brk_data_kept", int'(rx_data), 8'hA5);
        check("brk_busy_lo", int'(busy), 0);
        v0 = n_valid;
        send_frame(8'h11, 1'b1);
        hold(1'b1, 4);
        check("rec_count", n_valid - v0, 1);
        check("rec_data", int'(rx_data), 8'h11);

        // Back-to-back frames with no idle gap
        v0 = n_valid;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold(1'b1, 4);
        check("b2b_count", n_valid - v0, 2);
        check("b2b_first", int'(data_log[4'(v0)]), 8'h00);
        check("b2b_second", int'(data_log[4'(v0 + 1)]), 8'hFF);

        // Reset in the middle of data bit 4 aborts the frame
        v0 = n_valid; f0 = n_ferr;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(1'(8'h5A >> i), BIT);
        hold(1'b1, BIT / 2);
        reset_p = 1'b1;
        @(negedge clk);
        reset_p = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_data", int'(rx_data), 0);
        hold(1'b1, 2 * BIT);
        check("abort_valid", n_valid - v0, 0);
        send_frame(8'h5A, 1'b1);
        hold(1'b1, 4);
        check("post_rst_count", n_valid - v0, 1);
        check("post_rst_data", int'(rx_data), 8'h5A);
        check("post_rst_ferr", n_ferr - f0, 0);

`ifdef UART_RX_PARITY_EN
        // 0x01 with even parity expects a parity bit of 1; send 0
        v0 = n_valid; f0 = n_perr_valid;
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(i == 0, BIT);
        hold(1'b0, BIT);
        hold(1'b1, BIT);
        hold(1'b1, 4);
        check("par_valid", n_valid - v0, 1);
        check("par_with_valid", n_perr_valid - f0, 1);
        check("par_data", int'(rx_data), 8'h01);
        check("par_total", n_perr, 1);
`else
        check("par_total", n_perr, 0);
`endif
        check("valid_ferr_overlap", n_overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
